// File: rtl/fft_stream_gen.sv
// -----------------------------------------------------------------------------
// fft_stream_gen
//
// Source of FFT-output-style frames (data/valid/sop/eop) for exercising the
// spectrum display path without a real FFT core. A small FSM walks a sample
// index through each frame. A registered generator stage turns that index into
// a sample according to the selected pattern. An equal-depth delay line then
// carries data and flags to the outputs.
//
// Handshake: there is no back-pressure. fft_valid qualifies fft_data, fft_sop
// and fft_eop on every cycle it is high. When fft_valid is low, data, sop and
// eop are driven to zero.
//
// Ports:
//   sys_clk     system clock
//   rst_n       asynchronous active-low reset
//   start       single-cycle pulse, begins a run when idle
//   stop        level, ends the run at the next frame boundary
//   mode        0 ramp, 1 constant, 2 single tone, 3 LFSR (sampled at idx 0)
//   frames_req  frames per run, 0 = continuous until stop
//   tone_bin    bin index carrying tone_mag in mode 2
//   tone_mag    constant value (mode 1) / tone-bin value (mode 2)
//   fft_data    sample
//   fft_valid   sample qualifier
//   fft_sop     first sample of a frame
//   fft_eop     last sample of a frame
//   busy        run active or samples still in the delay line
//   frame_cnt   frames whose eop has reached the output in the current run
//
// The FSM state is held in the signal "state" (type state_t) for observation.
// -----------------------------------------------------------------------------
module fft_stream_gen #(
    parameter int          DATA_W    = 32,
    parameter int          FRAME_LEN = 256,
    parameter int          GAP_LEN   = 0,
    parameter int          DELAY     = 20,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2024
) (
    input  logic                         sys_clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic [1:0]                   mode,
    input  logic [15:0]                  frames_req,
    input  logic [$clog2(FRAME_LEN)-1:0] tone_bin,
    input  logic [DATA_W-1:0]            tone_mag,
    output logic [DATA_W-1:0]            fft_data,
    output logic                         fft_valid,
    output logic                         fft_sop,
    output logic                         fft_eop,
    output logic                         busy,
    output logic [15:0]                  frame_cnt
);

    localparam int          IDX_W     = $clog2(FRAME_LEN);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_LEN - 1);
    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_CONST = 2'd1;
    localparam logic [1:0] MODE_TONE  = 2'd2;
    localparam logic [1:0] MODE_LFSR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Sequencer registers
    logic [IDX_W-1:0]  idx;
    logic [15:0]       gap_cnt;
    logic [15:0]       issued_cnt;
    logic [15:0]       req_lat;
    logic              stop_flag;
    logic [1:0]        mode_lat;
    logic [IDX_W-1:0]  bin_lat;
    logic [DATA_W-1:0] mag_lat;
    logic [31:0]       lfsr;

    // Control decoded by the FSM
    logic start_run;
    logic emit;
    logic frame_end;
    logic stop_any;
    logic last_frame;
    logic pipe_empty;

    // Pattern selection and generator stage
    logic [1:0]        cur_mode;
    logic [IDX_W-1:0]  cur_bin;
    logic [DATA_W-1:0] cur_mag;
    logic [31:0]       lfsr_nxt;
    logic [DATA_W-1:0] sample;

    logic [DATA_W-1:0] g_data;
    logic              g_valid;
    logic              g_sop;
    logic              g_eop;

    // A stop seen in the very cycle of the frame end still counts.
    assign stop_any   = stop_flag | stop;
    assign last_frame = (req_lat != 16'd0) &&
                        ((17'(issued_cnt) + 17'd1) == 17'(req_lat));

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        emit      = 1'b0;
        frame_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                emit = 1'b1;
                // FRAME_LEN is a power of two, so the last index is all ones.
                if (&idx) begin
                    frame_end = 1'b1;
                    if (stop_any || last_frame) begin
                        state_nxt = S_DONE;
                    end else if (GAP_LEN > 0) begin
                        state_nxt = S_GAP;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = stop_any ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                if (pipe_empty) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencer datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            gap_cnt    <= '0;
            issued_cnt <= '0;
            req_lat    <= '0;
            stop_flag  <= 1'b0;
            mode_lat   <= MODE_RAMP;
            bin_lat    <= '0;
            mag_lat    <= '0;
            lfsr       <= LFSR_SEED;
        end else if (start_run) begin
            idx        <= '0;
            gap_cnt    <= '0;
            issued_cnt <= '0;
            req_lat    <= frames_req;
            // start+stop together still produces one complete frame.
            stop_flag  <= stop;
            lfsr       <= LFSR_SEED;
        end else begin
            if (state == S_RUN || state == S_GAP) begin
                stop_flag <= stop_flag | stop;
            end
            if (emit) begin
                // Wraps to 0 at the frame end, ready for the next frame.
                idx <= idx + 1'b1;
                if (idx == '0) begin
                    mode_lat <= mode;
                    bin_lat  <= tone_bin;
                    mag_lat  <= tone_mag;
                end
                if (frame_end) begin
                    issued_cnt <= issued_cnt + 16'd1;
                end
                if (cur_mode == MODE_LFSR) begin
                    lfsr <= lfsr_nxt;
                end
            end
            if (state == S_GAP) begin
                gap_cnt <= (gap_cnt == GAP_LAST) ? 16'd0 : gap_cnt + 16'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pattern generator. At idx 0 the live inputs are used directly; the
    // latched copies hold them for the rest of the frame.
    // -------------------------------------------------------------------------
    assign cur_mode = (idx == '0) ? mode     : mode_lat;
    assign cur_bin  = (idx == '0) ? tone_bin : bin_lat;
    assign cur_mag  = (idx == '0) ? tone_mag : mag_lat;
    assign lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);

    always_comb begin
        sample = '0;
        case (cur_mode)
            MODE_RAMP:  sample = DATA_W'(idx);
            MODE_CONST: sample = cur_mag;
            MODE_TONE:  sample = (idx == cur_bin) ? cur_mag : '0;
            MODE_LFSR:  sample = DATA_W'(lfsr_nxt);
            default:    sample = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            g_data  <= '0;
            g_valid <= 1'b0;
            g_sop   <= 1'b0;
            g_eop   <= 1'b0;
        end else begin
            g_data  <= emit ? sample : '0;
            g_valid <= emit;
            g_sop   <= emit && (idx == '0);
            g_eop   <= frame_end;
        end
    end

    // -------------------------------------------------------------------------
    // Output delay line: identical depth for data and all flags.
    // -------------------------------------------------------------------------
    generate
        if (DELAY == 0) begin : g_nodelay
            assign fft_data   = g_data;
            assign fft_valid  = g_valid;
            assign fft_sop    = g_sop;
            assign fft_eop    = g_eop;
            assign pipe_empty = !g_valid;
        end else begin : g_delay
            logic [DATA_W-1:0] d_pipe [DELAY];
            logic [DELAY-1:0]  v_pipe;
            logic [DELAY-1:0]  s_pipe;
            logic [DELAY-1:0]  e_pipe;

            always_ff @(posedge sys_clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DELAY; i++) begin
                        d_pipe[i] <= '0;
                    end
                    v_pipe <= '0;
                    s_pipe <= '0;
                    e_pipe <= '0;
                end else begin
                    d_pipe[0] <= g_data;
                    v_pipe[0] <= g_valid;
                    s_pipe[0] <= g_sop;
                    e_pipe[0] <= g_eop;
                    for (int i = 1; i < DELAY; i++) begin
                        d_pipe[i] <= d_pipe[i-1];
                        v_pipe[i] <= v_pipe[i-1];
                        s_pipe[i] <= s_pipe[i-1];
                        e_pipe[i] <= e_pipe[i-1];
                    end
                end
            end

            assign fft_data   = d_pipe[DELAY-1];
            assign fft_valid  = v_pipe[DELAY-1];
            assign fft_sop    = s_pipe[DELAY-1];
            assign fft_eop    = e_pipe[DELAY-1];
            assign pipe_empty = !g_valid && (v_pipe == '0);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Status
    // -------------------------------------------------------------------------
    // DONE only returns to IDLE once every sample has left, so busy covers
    // the drain without extra bookkeeping.
    assign busy = (state != S_IDLE);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (start_run) begin
            frame_cnt <= '0;
        end else if (fft_valid && fft_eop) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fft_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_fft_stream_gen
//
// Directed bench for fft_stream_gen. Instance "a" uses the default
// parameters (FRAME_LEN=256, GAP_LEN=0, DELAY=20); instance "b" uses
// FRAME_LEN=8, GAP_LEN=4, DELAY=0. Inputs change and outputs are sampled on
// the falling clock edge. Cycle numbers in the tasks count falling edges,
// with cycle 0 being the one in which start is held high.
// -----------------------------------------------------------------------------
module tb_fft_stream_gen;

    logic clk;
    logic rst_n;

    // Instance a
    logic        start_a, stop_a;
    logic [1:0]  mode_a;
    logic [15:0] frames_req_a;
    logic [7:0]  tone_bin_a;
    logic [31:0] tone_mag_a;
    logic [31:0] data_a;
    logic        valid_a, sop_a, eop_a, busy_a;
    logic [15:0] fcnt_a;

    // Instance b
    logic        start_b, stop_b;
    logic [1:0]  mode_b;
    logic [15:0] frames_req_b;
    logic [2:0]  tone_bin_b;
    logic [31:0] tone_mag_b;
    logic [31:0] data_b;
    logic        valid_b, sop_b, eop_b, busy_b;
    logic [15:0] fcnt_b;

    int n_checks;
    int n_fail;

    fft_stream_gen dut_a (
        .sys_clk    (clk),
        .rst_n      (rst_n),
        .start      (start_a),
        .stop       (stop_a),
        .mode       (mode_a),
        .frames_req (frames_req_a),
        .tone_bin   (tone_bin_a),
        .tone_mag   (tone_mag_a),
        .fft_data   (data_a),
        .fft_valid  (valid_a),
        .fft_sop    (sop_a),
        .fft_eop    (eop_a),
        .busy       (busy_a),
        .frame_cnt  (fcnt_a)
    );

    fft_stream_gen #(
        .FRAME_LEN (8),
        .GAP_LEN   (4),
        .DELAY     (0)
    ) dut_b (
        .sys_clk    (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .stop       (stop_b),
        .mode       (mode_b),
        .frames_req (frames_req_b),
        .tone_bin   (tone_bin_b),
        .tone_mag   (tone_mag_b),
        .fft_data   (data_b),
        .fft_valid  (valid_b),
        .fft_sop    (sop_b),
        .fft_eop    (eop_b),
        .busy       (busy_b),
        .frame_cnt  (fcnt_b)
    );

    // ---------------------------------------------------------------- clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        n_checks++;
        if ({data_a, valid_a, sop_a, eop_a, busy_a, fcnt_a} !== 52'd0) begin
            n_fail++;
            $display("FAIL reset_a: got data=%0h v=%0b s=%0b e=%0b busy=%0b fcnt=%0d expected all 0",
                     data_a, valid_a, sop_a, eop_a, busy_a, fcnt_a);
        end
        n_checks++;
        if ({data_b, valid_b, sop_b, eop_b, busy_b, fcnt_b} !== 52'd0) begin
            n_fail++;
            $display("FAIL reset_b: got data=%0h v=%0b s=%0b e=%0b busy=%0b fcnt=%0d expected all 0",
                     data_b, valid_b, sop_b, eop_b, busy_b, fcnt_b);
        end
    endtask

    // Defaults, ramp, 3 frames. Start is labelled cycle 10 here so the
    // numbers match the hand-derived timeline (first sop at 32, busy low 801).
    task automatic test_ramp();
        int first_v = -1, first_eop = -1, last_v = -1, busy_fall = -1;
        int n_valid = 0, n_sop = 0, n_eop = 0, pat_err = 0;
        logic [31:0] first_data = '0, eop_data = '0;
        logic first_sop = 1'b0, busy_11 = 1'b0;
        mode_a = 2'd0; frames_req_a = 16'd3; start_a = 1'b1;
        for (int c = 11; c <= 830; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (c == 11) busy_11 = busy_a;
            if (valid_a) begin
                if (first_v < 0) begin
                    first_v = c; first_data = data_a; first_sop = sop_a;
                end
                if (data_a !== 32'(n_valid % 256)) pat_err++;
                if (sop_a !== ((n_valid % 256) == 0)) pat_err++;
                if (eop_a !== ((n_valid % 256) == 255)) pat_err++;
                if (sop_a) n_sop++;
                if (eop_a) begin
                    n_eop++;
                    if (first_eop < 0) begin first_eop = c; eop_data = data_a; end
                end
                n_valid++;
                last_v = c;
            end
            if (c > 11 && !busy_a && busy_fall < 0) busy_fall = c;
        end
        n_checks++; if (busy_11 !== 1'b1) begin n_fail++; $display("FAIL ramp_busy_rise: got %0b expected 1", busy_11); end
        n_checks++; if (first_v != 32) begin n_fail++; $display("FAIL ramp_first_valid_cycle: got %0d expected 32", first_v); end
        n_checks++; if (first_data !== 32'd0) begin n_fail++; $display("FAIL ramp_first_data: got %0d expected 0", first_data); end
        n_checks++; if (first_sop !== 1'b1) begin n_fail++; $display("FAIL ramp_first_sop: got %0b expected 1", first_sop); end
        n_checks++; if (first_eop != 287) begin n_fail++; $display("FAIL ramp_eop_cycle: got %0d expected 287", first_eop); end
        n_checks++; if (eop_data !== 32'd255) begin n_fail++; $display("FAIL ramp_eop_data: got %0d expected 255", eop_data); end
        n_checks++; if (n_valid != 768) begin n_fail++; $display("FAIL ramp_valid_count: got %0d expected 768", n_valid); end
        n_checks++; if (last_v != 799) begin n_fail++; $display("FAIL ramp_last_valid_cycle: got %0d expected 799", last_v); end
        n_checks++; if (pat_err != 0) begin n_fail++; $display("FAIL ramp_pattern: got %0d bad samples expected 0", pat_err); end
        n_checks++; if (n_sop != 3 || n_eop != 3) begin n_fail++; $display("FAIL ramp_sop_eop_count: got %0d/%0d expected 3/3", n_sop, n_eop); end
        n_checks++; if (fcnt_a !== 16'd3) begin n_fail++; $display("FAIL ramp_frame_cnt: got %0d expected 3", fcnt_a); end
        n_checks++; if (busy_fall != 801) begin n_fail++; $display("FAIL ramp_busy_fall: got %0d expected 801", busy_fall); end
    endtask

    // Instance b, constant 0x55, 2 frames with a 4-cycle gap. A second start
    // pulse at cycle 5 must be ignored.
    task automatic test_gap();
        logic        exp_v;
        logic [35:0] exp_w, obs_w;
        mode_b = 2'd1; tone_mag_b = 32'h55; frames_req_b = 16'd2; start_b = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            exp_v = (c >= 2 && c <= 9) || (c >= 14 && c <= 21);
            exp_w = {exp_v, exp_v && (c == 2 || c == 14), exp_v && (c == 9 || c == 21),
                     (exp_v ? 32'h55 : 32'h0), (c <= 22)};
            obs_w = {valid_b, sop_b, eop_b, data_b, busy_b};
            n_checks++;
            if (obs_w !== exp_w) begin
                n_fail++;
                $display("FAIL gap_cycle_%0d: got v=%0b s=%0b e=%0b d=%0h busy=%0b expected v=%0b s=%0b e=%0b d=%0h busy=%0b",
                         c, obs_w[35], obs_w[34], obs_w[33], obs_w[32:1], obs_w[0],
                         exp_w[35], exp_w[34], exp_w[33], exp_w[32:1], exp_w[0]);
            end
            if (c == 12) begin
                n_checks++;
                if (fcnt_b !== 16'd1) begin n_fail++; $display("FAIL gap_frame_cnt_mid: got %0d expected 1", fcnt_b); end
            end
            start_b = (c == 5);
        end
        n_checks++; if (fcnt_b !== 16'd2) begin n_fail++; $display("FAIL gap_frame_cnt: got %0d expected 2", fcnt_b); end
    endtask

    // start and stop together while idle, continuous request: one frame only.
    task automatic test_start_stop_same();
        int n_valid = 0, pat_err = 0;
        logic busy_10 = 1'b0, busy_11 = 1'b1;
        mode_b = 2'd0; frames_req_b = 16'd0; start_b = 1'b1; stop_b = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start_b = 1'b0; stop_b = 1'b0;
            if (valid_b) begin
                if (data_b !== 32'(n_valid)) pat_err++;
                n_valid++;
            end
            if (c == 10) busy_10 = busy_b;
            if (c == 11) busy_11 = busy_b;
        end
        n_checks++; if (n_valid != 8) begin n_fail++; $display("FAIL ss_valid_count: got %0d expected 8", n_valid); end
        n_checks++; if (pat_err != 0) begin n_fail++; $display("FAIL ss_pattern: got %0d bad expected 0", pat_err); end
        n_checks++; if (fcnt_b !== 16'd1) begin n_fail++; $display("FAIL ss_frame_cnt: got %0d expected 1", fcnt_b); end
        n_checks++; if (busy_10 !== 1'b1 || busy_11 !== 1'b0) begin n_fail++; $display("FAIL ss_busy_fall: got %0b%0b expected 10", busy_10, busy_11); end
    endtask

    task automatic test_tone();
        int n_valid = 0, nz_cnt = 0, nz_idx = -1;
        logic [31:0] nz_val = '0;
        mode_a = 2'd2; tone_bin_a = 8'd17; tone_mag_a = 32'd1000; frames_req_a = 16'd1; start_a = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (valid_a) begin
                if (data_a !== 32'd0) begin nz_cnt++; nz_idx = n_valid; nz_val = data_a; end
                n_valid++;
            end
        end
        n_checks++; if (n_valid != 256) begin n_fail++; $display("FAIL tone_valid_count: got %0d expected 256", n_valid); end
        n_checks++; if (nz_cnt != 1) begin n_fail++; $display("FAIL tone_nonzero_count: got %0d expected 1", nz_cnt); end
        n_checks++; if (nz_idx != 17) begin n_fail++; $display("FAIL tone_bin_index: got %0d expected 17", nz_idx); end
        n_checks++; if (nz_val !== 32'd1000) begin n_fail++; $display("FAIL tone_value: got %0d expected 1000", nz_val); end
        n_checks++; if (fcnt_a !== 16'd1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL tone_end_state: got fcnt=%0d busy=%0b expected 1/0", fcnt_a, busy_a); end
    endtask

    // Continuous run; one-cycle stop at FSM idx 100 of the second frame
    // (FSM cycle 1 + 256 + 100 = 357).
    task automatic test_stop();
        int n_valid = 0, pat_err = 0, last_v = -1, busy_fall = -1;
        mode_a = 2'd0; frames_req_a = 16'd0; start_a = 1'b1;
        for (int c = 1; c <= 620; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (valid_a) begin
                if (data_a !== 32'(n_valid % 256)) pat_err++;
                n_valid++;
                last_v = c;
            end
            if (!busy_a && busy_fall < 0) busy_fall = c;
            stop_a = (c == 357);
        end
        n_checks++; if (n_valid != 512) begin n_fail++; $display("FAIL stop_valid_count: got %0d expected 512", n_valid); end
        n_checks++; if (last_v != 533) begin n_fail++; $display("FAIL stop_last_valid: got %0d expected 533", last_v); end
        n_checks++; if (pat_err != 0) begin n_fail++; $display("FAIL stop_pattern: got %0d bad expected 0", pat_err); end
        n_checks++; if (fcnt_a !== 16'd2) begin n_fail++; $display("FAIL stop_frame_cnt: got %0d expected 2", fcnt_a); end
        n_checks++; if (busy_fall != 535) begin n_fail++; $display("FAIL stop_busy_fall: got %0d expected 535", busy_fall); end
    endtask

    // Mode switched 0 -> 3 at FSM idx 50 of frame 1 (cycle 51). The LFSR
    // values are the seed 0xACE12024 stepped by hand with mask 0x80200003.
    task automatic test_mode_change();
        int n_valid = 0, ramp_err = 0;
        logic [31:0] obs [4];
        logic [31:0] exp_l [4];
        exp_l[0] = 32'h5670_9012;
        exp_l[1] = 32'h2B38_4809;
        exp_l[2] = 32'h95BC_2407;
        exp_l[3] = 32'hCAFE_1200;
        for (int k = 0; k < 4; k++) obs[k] = '0;
        mode_a = 2'd0; frames_req_a = 16'd2; start_a = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (valid_a) begin
                if (n_valid < 256 && data_a !== 32'(n_valid)) ramp_err++;
                if (n_valid >= 256 && n_valid < 260) obs[n_valid-256] = data_a;
                n_valid++;
            end
            if (c == 51) mode_a = 2'd3;
        end
        n_checks++; if (ramp_err != 0) begin n_fail++; $display("FAIL mode_first_frame_ramp: got %0d bad expected 0", ramp_err); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs[k] !== exp_l[k]) begin
                n_fail++;
                $display("FAIL mode_lfsr_%0d: got %08h expected %08h", k, obs[k], exp_l[k]);
            end
        end
        n_checks++; if (n_valid != 512 || fcnt_a !== 16'd2) begin n_fail++; $display("FAIL mode_totals: got %0d/%0d expected 512/2", n_valid, fcnt_a); end
        mode_a = 2'd0;
    endtask

    // One-cycle reset mid-frame, then a clean restart.
    task automatic test_reset_mid();
        int n_bad = 0, first_v = -1;
        logic [31:0] first_data = 32'hFFFF_FFFF;
        mode_a = 2'd0; frames_req_a = 16'd0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (99) @(negedge clk);
        n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL rmid_running: got %0b expected 1", valid_a); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({data_a, valid_a, sop_a, eop_a, busy_a, fcnt_a} !== 52'd0) begin
            n_fail++;
            $display("FAIL rmid_outputs_cleared: got data=%0h v=%0b busy=%0b fcnt=%0d expected all 0",
                     data_a, valid_a, busy_a, fcnt_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (valid_a !== 1'b0 || busy_a !== 1'b0) n_bad++;
        end
        n_checks++; if (n_bad != 0) begin n_fail++; $display("FAIL rmid_quiet_after_reset: got %0d active cycles expected 0", n_bad); end
        start_a = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (valid_a && first_v < 0) begin first_v = c; first_data = data_a; end
        end
        n_checks++; if (first_v != 22) begin n_fail++; $display("FAIL rmid_restart_latency: got %0d expected 22", first_v); end
        n_checks++; if (first_data !== 32'd0) begin n_fail++; $display("FAIL rmid_restart_data: got %0d expected 0", first_data); end
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        start_a = 1'b0; stop_a = 1'b0; mode_a = 2'd0; frames_req_a = 16'd0;
        tone_bin_a = 8'd0; tone_mag_a = 32'd0;
        start_b = 1'b0; stop_b = 1'b0; mode_b = 2'd0; frames_req_b = 16'd0;
        tone_bin_b = 3'd0; tone_mag_b = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_ramp();
        @(negedge clk);
        test_gap();
        @(negedge clk);
        test_start_stop_same();
        @(negedge clk);
        test_tone();
        @(negedge clk);
        test_stop();
        @(negedge clk);
        test_mode_change();
        @(negedge clk);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
